// File: rtl/im_prefetch_pkg.sv
// Shared constants, FSM encoding and sizing helper for the instruction prefetch front end.
package im_prefetch_pkg;

  localparam int          IM_ADDR_W = 10;
  localparam int          INST_W    = 32;
  localparam int unsigned RESET_PC  = 32'd0;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/im_prefetch_fifo.sv
// Synchronous {pc, word} FIFO with wrap-bit pointers, plus its overflow checker.
module inst_fifo_chk (
  input logic clk_i,
  input logic rst_i,
  input logic clear_i,
  input logic push_i,
  input logic full_i
);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i || clear_i) !(push_i && full_i));

endmodule

module inst_fifo
  import im_prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 42
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            wdata_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            rdata_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [cnt_width(DEPTH)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push_s;
  logic             do_pop_s;

  // Status flags, guarded push/pop and zero-when-empty head read.
  always_comb begin
    empty_o   = (wr_ptr_q == rd_ptr_q);
    full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count_o   = wr_ptr_q - rd_ptr_q;
    do_push_s = push_i && !full_o;
    do_pop_s  = pop_i && !empty_o;
    if (empty_o) begin
      rdata_o = '0;
    end else begin
      rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  // Storage write; no reset needed since empty reads are forced to zero.
  always_ff @(posedge clk_i) begin
    if (do_push_s && !clear_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  // Pointer update; clear outranks push and pop.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  inst_fifo_chk u_chk (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (push_i),
    .full_i  (full_o)
  );

endmodule

// File: rtl/im_prefetch.sv
// Instruction fetch front end: sequential IM reads buffered in a FIFO, flushed on redirect.
module im_prefetch #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = im_prefetch_pkg::IM_ADDR_W,
  parameter int          DATA_W   = im_prefetch_pkg::INST_W,
  parameter int unsigned RESET_PC = im_prefetch_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              IM_enable,
  output logic              IM_read,
  output logic              IM_write,
  output logic [ADDR_W-1:0] IM_address,
  input  logic [DATA_W-1:0] IM_out
);

  import im_prefetch_pkg::*;

  localparam int CNT_W = cnt_width(DEPTH);

  state_t             state_q;
  logic [ADDR_W-1:0]  fetch_pc_q;
  logic [ADDR_W-1:0]  tag_q;
  logic               inflight_q;
  logic [CNT_W-1:0]   count_s;
  logic               full_s;
  logic               empty_s;
  logic               issue_s;
  logic               push_s;
  logic               pop_s;

  // Occupancy counts in-flight words but not this cycle's pop; redirect suppresses the request.
  always_comb begin
    if ((state_q == ST_RUN) && !redirect_valid && !full_s &&
        ((int'(count_s) + int'(inflight_q)) < DEPTH)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    push_s = inflight_q && !redirect_valid;
    pop_s  = !empty_s && inst_ready;
  end

  // Control FSM with fetch pointer and in-flight tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= ADDR_W'(RESET_PC);
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else if (redirect_valid) begin
      state_q    <= ST_FLUSH;
      fetch_pc_q <= redirect_pc;
      inflight_q <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT:  state_q <= ST_RUN;
        ST_RUN:   state_q <= ST_RUN;
        ST_FLUSH: state_q <= ST_RUN;
        default:  state_q <= ST_BOOT;
      endcase
      inflight_q <= issue_s;
      if (issue_s) begin
        tag_q      <= fetch_pc_q;
        fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
      end
    end
  end

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (redirect_valid),
    .push_i  (push_s),
    .wdata_i ({tag_q, IM_out}),
    .pop_i   (pop_s),
    .rdata_o ({inst_pc, instruction}),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  assign inst_valid = !empty_s;
  assign IM_enable  = issue_s;
  assign IM_read    = issue_s;
  assign IM_write   = 1'b0;
  assign IM_address = fetch_pc_q;

endmodule

// File: tb/tb_im_prefetch.sv
// Randomized self-checking bench for im_prefetch against a request/delivery timing model.
module tb_im_prefetch;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] instruction;
  logic [ADDR_W-1:0] inst_pc;
  logic              IM_enable;
  logic              IM_read;
  logic              IM_write;
  logic [ADDR_W-1:0] IM_address;
  logic [DATA_W-1:0] IM_out;
  logic [DATA_W-1:0] im_q;

  logic [DATA_W-1:0] mem_words [1 << ADDR_W];

  int checks   = 0;
  int failures = 0;
  int en_seen  = 0;

  // Model: requests issued this epoch (cycle and pc), words accepted, next expected fetch pc.
  int                cyc      = 0;
  int                ep_start = 0;
  int                req_cyc [$];
  logic [ADDR_W-1:0] req_pc  [$];
  int                n_pop    = 0;
  logic [ADDR_W-1:0] next_pc  = '0;

  im_prefetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .instruction    (instruction),
    .inst_pc        (inst_pc),
    .IM_enable      (IM_enable),
    .IM_read        (IM_read),
    .IM_write       (IM_write),
    .IM_address     (IM_address),
    .IM_out         (IM_out)
  );

  always #5 clk = ~clk;

  // Instruction memory: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    if (IM_enable) im_q <= mem_words[IM_address];
    else           im_q <= $urandom;
  end
  assign IM_out = im_q;

  task automatic run_cycle(input logic rv, input logic [ADDR_W-1:0] rpc, input logic rdy);
    logic exp_en;
    logic exp_valid;
    int   landed;
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    @(negedge clk);
    exp_en = !rv && (cyc > ep_start) && ((req_pc.size() - n_pop) < DEPTH);
    landed = 0;
    foreach (req_cyc[i]) if (req_cyc[i] <= cyc - 2) landed++;
    exp_valid = landed > n_pop;
    if (IM_enable === 1'b1) en_seen++;
    checks++;
    if (IM_enable !== exp_en) begin
      failures++; $display("FAIL im_enable cyc=%0d got=%0b exp=%0b", cyc, IM_enable, exp_en);
    end
    checks++;
    if (IM_read !== exp_en) begin
      failures++; $display("FAIL im_read cyc=%0d got=%0b exp=%0b", cyc, IM_read, exp_en);
    end
    checks++;
    if (IM_write !== 1'b0) begin
      failures++; $display("FAIL im_write cyc=%0d got=%0b exp=0", cyc, IM_write);
    end
    if (exp_en) begin
      checks++;
      if (IM_address !== next_pc) begin
        failures++; $display("FAIL im_address cyc=%0d got=%0h exp=%0h", cyc, IM_address, next_pc);
      end
    end
    checks++;
    if (inst_valid !== exp_valid) begin
      failures++; $display("FAIL inst_valid cyc=%0d got=%0b exp=%0b", cyc, inst_valid, exp_valid);
    end
    checks++;
    if (exp_valid) begin
      if (inst_pc !== req_pc[n_pop] || instruction !== mem_words[req_pc[n_pop]]) begin
        failures++;
        $display("FAIL head cyc=%0d got pc=%0h word=%0h exp pc=%0h word=%0h", cyc, inst_pc,
                 instruction, req_pc[n_pop], mem_words[req_pc[n_pop]]);
      end
    end else begin
      if (inst_pc !== '0 || instruction !== '0) begin
        failures++;
        $display("FAIL empty_head cyc=%0d got pc=%0h word=%0h exp 0/0", cyc, inst_pc, instruction);
      end
    end
    @(posedge clk);
    #1;
    if (rv) begin
      ep_start = cyc + 1;
      req_cyc.delete();
      req_pc.delete();
      n_pop   = 0;
      next_pc = rpc;
    end else begin
      if (exp_en) begin
        req_cyc.push_back(cyc);
        req_pc.push_back(next_pc);
        next_pc = next_pc + 10'd1;
      end
      if (exp_valid && rdy) n_pop++;
    end
    cyc++;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    checks++;
    if ({inst_valid, IM_enable, IM_read, IM_write} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got valid/en/rd/wr=%b exp=0000", {inst_valid, IM_enable, IM_read, IM_write});
    end
    checks++;
    if (instruction !== '0 || inst_pc !== '0) begin
      failures++; $display("FAIL reset_head got pc=%0h word=%0h exp 0/0", inst_pc, instruction);
    end
    rst      = 1'b0;
    ep_start = cyc;
    req_cyc.delete();
    req_pc.delete();
    n_pop   = 0;
    next_pc = '0;
  endtask

  task automatic test_stream();
    test_reset();
    for (int i = 0; i < 16; i++) run_cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_backpressure();
    test_reset();
    en_seen = 0;
    for (int i = 0; i < 20; i++) run_cycle(1'b0, '0, 1'b0);
    checks++;
    if (en_seen !== DEPTH) begin
      failures++; $display("FAIL stall_requests got=%0d exp=%0d", en_seen, DEPTH);
    end
    for (int i = 0; i < 10; i++) run_cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_redirect();
    test_reset();
    for (int i = 0; i < 5; i++) run_cycle(1'b0, '0, 1'b0);
    run_cycle(1'b1, 10'h200, 1'b0);
    for (int i = 0; i < 8; i++) run_cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_wrap();
    run_cycle(1'b1, 10'h3FF, 1'b1);
    for (int i = 0; i < 10; i++) run_cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_redirect_pop_push();
    test_reset();
    for (int i = 0; i < 6; i++) run_cycle(1'b0, '0, 1'b1);
    run_cycle(1'b1, 10'(($urandom_range(1, 1000))), 1'b1);
    for (int i = 0; i < 8; i++) run_cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) run_cycle(1'b0, '0, 1'b0);
    test_reset();
    for (int i = 0; i < 8; i++) run_cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_random();
    test_reset();
    for (int i = 0; i < 400; i++) begin
      run_cycle(($urandom_range(0, 19) == 0), 10'($urandom), ($urandom_range(0, 3) != 0));
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem_words[i] = $urandom;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_redirect_pop_push();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
